csr_access_ctrl: RTL and testbench

Sequences CSR instructions from the pipeline's CSR stage onto a bank of NumCsr single-register CSR instances. Each instance has a write-enable and write-data input, a read-data output and a shadow-mismatch read-error output. The block performs read-modify-write for CSRRW/CSRRS/CSRRC, gives trap-unit writes (e.g. mepc/mcause) priority over pipeline requests, and aggregates shadow-copy integrity errors into a sticky alert.

---
 rtl/csr_access_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// Purpose : sequences pipeline CSR read/write/set/clear instructions onto a bank of
//           single-register CSR instances, gives trap-unit writes priority over the
//           pipeline and folds shadow-copy integrity errors into a sticky alert.
// Latency : accept -> cpu_rsp_valid_o is 3 cycles when a write is issued, 2 otherwise;
//           a trap write reaches the bank the cycle after it is seen in IDLE.
// Backpressure: one operation in flight; cpu_req_ready_o is low outside IDLE and while
//           a trap is pending; the response is held stable until cpu_rsp_ready_i.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cpu_req_*           pipeline request (valid/ready), index, op (00 rd 01 wr 10 set 11 clr), operand
//   cpu_rsp_*           response (valid/ready), old CSR value, error flag
//   trap_*              level trap write request held until trap_ack_o pulses
//   csr_wr_en_o/_data_o one-hot write strobe and shared write data to the bank
//   csr_rd_data_i/_error_i  flattened bank read data and per-entry shadow-mismatch flags
//   alert_o             sticky integrity alert, cleared only by reset

module csr_access_ctrl #(
  parameter  int NumCsr = 8,
  parameter  int Width  = 32,
  localparam int AddrW  = $clog2(NumCsr)
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    cpu_req_valid_i,
  output logic                    cpu_req_ready_o,
  input  logic [AddrW:0]          cpu_addr_i,
  input  logic [1:0]              cpu_op_i,
  input  logic [Width-1:0]        cpu_wdata_i,

  output logic                    cpu_rsp_valid_o,
  input  logic                    cpu_rsp_ready_i,
  output logic [Width-1:0]        cpu_rdata_o,
  output logic                    cpu_rsp_err_o,

  input  logic                    trap_req_i,
  input  logic [AddrW-1:0]        trap_addr_i,
  input  logic [Width-1:0]        trap_wdata_i,
  output logic                    trap_ack_o,

  output logic [NumCsr-1:0]       csr_wr_en_o,
  output logic [Width-1:0]        csr_wr_data_o,
  input  logic [NumCsr*Width-1:0] csr_rd_data_i,
  input  logic [NumCsr-1:0]       csr_rd_error_i,

  output logic                    alert_o
);

  localparam int IdxW = AddrW + 1;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    TRAP,
    READ,
    WRITE,
    RESP
  } state_e;

  state_e state;

  // Captured request, valid from READ until the operation returns to IDLE.
  logic [IdxW-1:0]  req_addr_q;
  logic [1:0]       req_op_q;
  logic [Width-1:0] req_wdata_q;

  // Bank lookup for the captured index. An index that matches no entry (MSB set
  // or beyond NumCsr) leaves idx_hit low, so the old value reads as zero.
  logic              idx_hit;
  logic [Width-1:0]  old_val;
  logic              old_err;
  logic [NumCsr-1:0] req_onehot;

  always_comb begin
    idx_hit    = 1'b0;
    old_val    = '0;
    old_err    = 1'b0;
    req_onehot = '0;
    for (int k = 0; k < NumCsr; k++) begin
      if (req_addr_q == IdxW'(k)) begin
        idx_hit       = 1'b1;
        old_val       = csr_rd_data_i[k*Width +: Width];
        old_err       = csr_rd_error_i[k];
        req_onehot[k] = 1'b1;
      end
    end
  end

  logic [NumCsr-1:0] trap_onehot;

  always_comb begin
    trap_onehot = '0;
    for (int k = 0; k < NumCsr; k++) begin
      trap_onehot[k] = (trap_addr_i == AddrW'(k));
    end
  end

  logic             rsp_err;
  logic [Width-1:0] new_val;
  logic             do_write;

  assign rsp_err = !idx_hit || old_err;

  always_comb begin
    new_val = old_val;
    case (req_op_q)
      OpWrite: new_val = req_wdata_q;
      OpSet:   new_val = old_val | req_wdata_q;
      OpClear: new_val = old_val & ~req_wdata_q;
      default: new_val = old_val;
    endcase
  end

  // Set/clear with a zero operand cannot change the register, so it is treated
  // like a read and skips the WRITE cycle. Any error suppresses the write.
  always_comb begin
    do_write = 1'b0;
    if (!rsp_err) begin
      do_write = (req_op_q == OpWrite) ||
                 (((req_op_q == OpSet) || (req_op_q == OpClear)) && (req_wdata_q != '0));
    end
  end

  // A pending trap blocks the pipeline even in IDLE so it wins a same-cycle race.
  assign cpu_req_ready_o = (state == IDLE) && !trap_req_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_addr_q      <= '0;
      req_op_q        <= OpRead;
      req_wdata_q     <= '0;
      csr_wr_en_o     <= '0;
      csr_wr_data_o   <= '0;
      trap_ack_o      <= 1'b0;
      cpu_rsp_valid_o <= 1'b0;
      cpu_rdata_o     <= '0;
      cpu_rsp_err_o   <= 1'b0;
    end else begin
      // Strobes are single-cycle; csr_wr_data_o keeps its last value.
      csr_wr_en_o <= '0;
      trap_ack_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (trap_req_i) begin
            state         <= TRAP;
            csr_wr_en_o   <= trap_onehot;
            csr_wr_data_o <= trap_wdata_i;
            trap_ack_o    <= 1'b1;
          end else if (cpu_req_valid_i) begin
            state       <= READ;
            req_addr_q  <= cpu_addr_i;
            req_op_q    <= cpu_op_i;
            req_wdata_q <= cpu_wdata_i;
          end
        end

        TRAP: begin
          state <= IDLE;
        end

        READ: begin
          // Response data is latched here and held untouched through RESP.
          cpu_rdata_o   <= old_val;
          cpu_rsp_err_o <= rsp_err;
          if (do_write) begin
            state         <= WRITE;
            csr_wr_en_o   <= req_onehot;
            csr_wr_data_o <= new_val;
          end else begin
            state           <= RESP;
            cpu_rsp_valid_o <= 1'b1;
          end
        end

        WRITE: begin
          state           <= RESP;
          cpu_rsp_valid_o <= 1'b1;
        end

        RESP: begin
          if (cpu_rsp_ready_i) begin
            state           <= IDLE;
            cpu_rsp_valid_o <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Any shadow mismatch anywhere in the bank latches the alert, whatever the
  // FSM is doing; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert_o <= 1'b0;
    end else if (|csr_rd_error_i) begin
      alert_o <= 1'b1;
    end
  end

  a_wr_en_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(csr_wr_en_o));

  a_wr_en_state: assert property (@(posedge clk) disable iff (!rst_n)
    (|csr_wr_en_o) |-> ((state == TRAP) || (state == WRITE)));

  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (cpu_rsp_valid_o && !cpu_rsp_ready_i) |=>
      (cpu_rsp_valid_o && $stable(cpu_rdata_o) && $stable(cpu_rsp_err_o)));

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: the bench owns a model of the CSR bank
// contents (exp_bank) and a response scoreboard; the simulated bank (bank) is
// written only by the DUT strobes. Inputs change and outputs are sampled on negedge.

module tb_csr_access_ctrl;

  localparam int N    = 8;
  localparam int W    = 32;
  localparam int AW   = 3;
  localparam int AWP1 = AW + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            cpu_req_valid_i = 1'b0;
  logic            cpu_req_ready_o;
  logic [AW:0]     cpu_addr_i      = '0;
  logic [1:0]      cpu_op_i        = 2'b00;
  logic [W-1:0]    cpu_wdata_i     = '0;
  logic            cpu_rsp_valid_o;
  logic            cpu_rsp_ready_i = 1'b0;
  logic [W-1:0]    cpu_rdata_o;
  logic            cpu_rsp_err_o;
  logic            trap_req_i      = 1'b0;
  logic [AW-1:0]   trap_addr_i     = '0;
  logic [W-1:0]    trap_wdata_i    = '0;
  logic            trap_ack_o;
  logic [N-1:0]    csr_wr_en_o;
  logic [W-1:0]    csr_wr_data_o;
  logic [N*W-1:0]  csr_rd_data_i;
  logic [N-1:0]    csr_rd_error_i  = '0;
  logic            alert_o;

  csr_access_ctrl #(.NumCsr(N), .Width(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_req_valid_i (cpu_req_valid_i),
    .cpu_req_ready_o (cpu_req_ready_o),
    .cpu_addr_i      (cpu_addr_i),
    .cpu_op_i        (cpu_op_i),
    .cpu_wdata_i     (cpu_wdata_i),
    .cpu_rsp_valid_o (cpu_rsp_valid_o),
    .cpu_rsp_ready_i (cpu_rsp_ready_i),
    .cpu_rdata_o     (cpu_rdata_o),
    .cpu_rsp_err_o   (cpu_rsp_err_o),
    .trap_req_i      (trap_req_i),
    .trap_addr_i     (trap_addr_i),
    .trap_wdata_i    (trap_wdata_i),
    .trap_ack_o      (trap_ack_o),
    .csr_wr_en_o     (csr_wr_en_o),
    .csr_wr_data_o   (csr_wr_data_o),
    .csr_rd_data_i   (csr_rd_data_i),
    .csr_rd_error_i  (csr_rd_error_i),
    .alert_o         (alert_o)
  );

  // Simulated CSR bank, written only through the DUT strobes.
  logic [W-1:0] bank [N] = '{32'h0000_0000, 32'h1111_1111, 32'h0000_00F0, 32'h3333_3333,
                             32'h4444_4444, 32'hFFFF_FFFF, 32'h6666_6666, 32'h7777_7777};
  // Bench-side expected bank contents, updated only from the bench's own predictions.
  logic [W-1:0] exp_bank [N] = '{32'h0000_0000, 32'h1111_1111, 32'h0000_00F0, 32'h3333_3333,
                                 32'h4444_4444, 32'hFFFF_FFFF, 32'h6666_6666, 32'h7777_7777};

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (csr_wr_en_o[k]) bank[k] <= csr_wr_data_o;
    end
  end

  always_comb begin
    csr_rd_data_i = '0;
    for (int k = 0; k < N; k++) csr_rd_data_i[k*W +: W] = bank[k];
  end

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
    int           lat;
    logic         dowr;
    logic [AW:0]  addr;
    logic [W-1:0] newv;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t predict(input logic [AW:0] a, input logic [1:0] op,
                                   input logic [W-1:0] wd);
    exp_t         e;
    logic         legal;
    logic [W-1:0] old;
    legal = (a < AWP1'(N));
    old   = legal ? exp_bank[a[AW-1:0]] : '0;
    e.err = !legal || csr_rd_error_i[a[AW-1:0]];
    case (op)
      2'b01:   e.newv = wd;
      2'b10:   e.newv = old | wd;
      2'b11:   e.newv = old & ~wd;
      default: e.newv = old;
    endcase
    e.dowr  = !e.err && ((op == 2'b01) || (op[1] && (wd != '0)));
    e.rdata = old;
    e.lat   = e.dowr ? 3 : 2;
    e.addr  = a;
    return e;
  endfunction

  task automatic drive_req(input logic [AW:0] a, input logic [1:0] op, input logic [W-1:0] wd);
    cpu_req_valid_i = 1'b1;
    cpu_addr_i      = a;
    cpu_op_i        = op;
    cpu_wdata_i     = wd;
  endtask

  // Issues one request at the current negedge and follows it to the response
  // handshake. hold = extra cycles with cpu_rsp_ready_i low; a trap can be
  // raised on the second hold cycle. Returns with the DUT back in IDLE.
  task automatic run_txn(input string tag, input logic [AW:0] a, input logic [1:0] op,
                         input logic [W-1:0] wd, input int hold, input bit trap_mid,
                         input logic [AW-1:0] ta, input logic [W-1:0] td, output int wait_cyc);
    exp_t         e;
    exp_t         got;
    int           k;
    bit           seen;
    logic [N-1:0] exp_oh;
    e = predict(a, op, wd);
    sb.push_back(e);
    if (e.dowr) exp_bank[a[AW-1:0]] = e.newv;
    exp_oh = '0;
    if (e.dowr) exp_oh[a[AW-1:0]] = 1'b1;
    drive_req(a, op, wd);
    #1;
    wait_cyc = 0;
    while (!cpu_req_ready_o && wait_cyc < 20) begin
      @(negedge clk);
      #1;
      wait_cyc++;
    end
    check_b({tag, "_accept"}, cpu_req_ready_o, 1'b1);
    @(negedge clk);
    cpu_req_valid_i = 1'b0;
    k    = 1;
    seen = 1'b0;
    while (!seen && k <= 8) begin
      if (e.dowr && k == 2) begin
        check_n({tag, "_wr_en"}, csr_wr_en_o, exp_oh);
        check_w({tag, "_wr_data"}, csr_wr_data_o, e.newv);
      end else begin
        check_n($sformatf("%s_no_wr_c%0d", tag, k), csr_wr_en_o, '0);
      end
      if (cpu_rsp_valid_o) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check_b({tag, "_rsp_seen"}, seen, 1'b1);
    if (seen) begin
      got = sb.pop_front();
      check_w({tag, "_latency"}, k, got.lat);
      check_w({tag, "_rdata"}, cpu_rdata_o, got.rdata);
      check_b({tag, "_err"}, cpu_rsp_err_o, got.err);
      for (int h = 0; h < hold; h++) begin
        if (trap_mid && h == 1) begin
          trap_req_i   = 1'b1;
          trap_addr_i  = ta;
          trap_wdata_i = td;
        end
        @(negedge clk);
        check_b($sformatf("%s_hold%0d_vld", tag, h), cpu_rsp_valid_o, 1'b1);
        check_w($sformatf("%s_hold%0d_rdata", tag, h), cpu_rdata_o, got.rdata);
        check_b($sformatf("%s_hold%0d_err", tag, h), cpu_rsp_err_o, got.err);
        check_n($sformatf("%s_hold%0d_wr_en", tag, h), csr_wr_en_o, '0);
        check_b($sformatf("%s_hold%0d_ack", tag, h), trap_ack_o, 1'b0);
      end
      cpu_rsp_ready_i = 1'b1;
      @(negedge clk);
      cpu_rsp_ready_i = 1'b0;
      check_b({tag, "_vld_drop"}, cpu_rsp_valid_o, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_n({tag, "_wr_en"}, csr_wr_en_o, '0);
    check_w({tag, "_wr_data"}, csr_wr_data_o, '0);
    check_b({tag, "_ack"}, trap_ack_o, 1'b0);
    check_b({tag, "_rsp_vld"}, cpu_rsp_valid_o, 1'b0);
    check_w({tag, "_rdata"}, cpu_rdata_o, '0);
    check_b({tag, "_err"}, cpu_rsp_err_o, 1'b0);
    check_b({tag, "_alert"}, alert_o, 1'b0);
    check_b({tag, "_ready"}, cpu_req_ready_o, 1'b1);
  endtask

  initial begin
    int wc;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Set with non-zero operand: write at +2, response at +3
    run_txn("set_csr2", 4'd2, 2'b10, 32'h0000_000F, 0, 1'b0, 3'd0, 32'h0, wc);
    check_w("bank2_after_set", bank[2], exp_bank[2]);

    // Clear with zero operand: no write, response at +2
    run_txn("clr_csr5", 4'd5, 2'b11, 32'h0, 0, 1'b0, 3'd0, 32'h0, wc);
    check_w("bank5_unchanged", bank[5], exp_bank[5]);

    // Illegal index, then a normal request right behind it
    run_txn("wr_idx9", 4'd9, 2'b01, 32'hCAFE_F00D, 0, 1'b0, 3'd0, 32'h0, wc);
    run_txn("rd_after_illegal", 4'd2, 2'b00, 32'h0, 0, 1'b0, 3'd0, 32'h0, wc);
    check_w("rd_after_illegal_wait", wc, 0);

    // Trap and cpu request in the same cycle: trap wins, cpu accepted next IDLE
    trap_req_i   = 1'b1;
    trap_addr_i  = 3'd3;
    trap_wdata_i = 32'h8000_0004;
    drive_req(4'd0, 2'b01, 32'h0000_ABCD);
    #1;
    check_b("trap_prio_ready", cpu_req_ready_o, 1'b0);
    @(negedge clk);
    check_n("trap_wr_en", csr_wr_en_o, 8'b0000_1000);
    check_w("trap_wr_data", csr_wr_data_o, 32'h8000_0004);
    check_b("trap_ack", trap_ack_o, 1'b1);
    trap_req_i  = 1'b0;
    exp_bank[3] = 32'h8000_0004;
    #1;
    check_b("trap_state_ready", cpu_req_ready_o, 1'b0);
    @(negedge clk);
    check_b("trap_ack_pulse_end", trap_ack_o, 1'b0);
    check_n("trap_wr_en_end", csr_wr_en_o, '0);
    run_txn("cpu_after_trap", 4'd0, 2'b01, 32'h0000_ABCD, 0, 1'b0, 3'd0, 32'h0, wc);
    check_w("cpu_after_trap_wait", wc, 0);
    check_w("bank3_trap", bank[3], exp_bank[3]);
    run_txn("rd_csr3", 4'd3, 2'b00, 32'h0, 0, 1'b0, 3'd0, 32'h0, wc);

    // Integrity error on CSR1: error response, no write, sticky alert
    check_b("alert_pre", alert_o, 1'b0);
    csr_rd_error_i = 8'b0000_0010;
    run_txn("integ_csr1", 4'd1, 2'b10, 32'h0000_0001, 0, 1'b0, 3'd0, 32'h0, wc);
    csr_rd_error_i = '0;
    check_b("alert_set", alert_o, 1'b1);
    repeat (3) @(negedge clk);
    check_b("alert_sticky", alert_o, 1'b1);
    check_w("bank1_untouched", bank[1], exp_bank[1]);

    // Response held 5 cycles while a trap arrives; trap served after handshake
    run_txn("hold_wr_csr6", 4'd6, 2'b01, 32'hA5A5_0000, 5, 1'b1, 3'd7, 32'hDEAD_BEEF, wc);
    check_b("trap_pending_ready", cpu_req_ready_o, 1'b0);
    check_n("trap_pending_wr_en", csr_wr_en_o, '0);
    check_b("trap_pending_ack", trap_ack_o, 1'b0);
    @(negedge clk);
    check_n("late_trap_wr_en", csr_wr_en_o, 8'b1000_0000);
    check_w("late_trap_wr_data", csr_wr_data_o, 32'hDEAD_BEEF);
    check_b("late_trap_ack", trap_ack_o, 1'b1);
    trap_req_i  = 1'b0;
    exp_bank[7] = 32'hDEAD_BEEF;
    @(negedge clk);
    check_w("bank6_written", bank[6], exp_bank[6]);
    check_w("bank7_trap", bank[7], exp_bank[7]);
    check_b("alert_before_rst", alert_o, 1'b1);

    // Reset asserted while in WRITE: write abandoned, everything back to reset values
    drive_req(4'd4, 2'b01, 32'h0000_1234);
    #1;
    check_b("rstw_accept", cpu_req_ready_o, 1'b1);
    @(negedge clk);
    cpu_req_valid_i = 1'b0;
    @(negedge clk);
    check_n("rstw_in_write", csr_wr_en_o, 8'b0001_0000);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_in_write");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_w("bank4_not_written", bank[4], exp_bank[4]);
    check_b("post_rst_rsp_vld", cpu_rsp_valid_o, 1'b0);
    run_txn("rd_csr4_after_rst", 4'd4, 2'b00, 32'h0, 0, 1'b0, 3'd0, 32'h0, wc);
    check_w("rd_csr4_after_rst_wait", wc, 0);
    check_w("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion by 100000 time units, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
